// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with a shared prescaled counter.
//
// A prescaler produces a tick every prescale+1 clocks while pwm_en is high. On each tick the
// shared counter advances through 0..period_act and wraps to 0. period_act is reloaded
// from the period input at every wrap and whenever the block is idle. Every channel owns a
// shadow and an active configuration {mode, cmp1, cmp2, pol}. A cfg_wr strobe writes a
// channel's shadow copy. The shadow copies move into the active copies at each wrap, and
// on every idle cycle, so a duty change never tears a period.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   pwm_en      1 = run, 0 = idle (counter cleared, outputs at their inactive level)
//   period      terminal count, sampled at wrap / while idle
//   prescale    tick divider (counter advances every prescale+1 clocks)
//   cfg_wr      one-cycle write strobe into the shadow copy of channel cfg_ch
//   cfg_ch      channel index; indices >= CHANNELS are ignored
//   cfg_mode    0 left, 1 right, 2 center, 3 window
//   cfg_cmp1/2  compare values
//   cfg_pol     1 = invert the channel output
//   pwm_out     registered PWM outputs, one bit per channel
//   count_val   current counter value
//   period_done one-cycle pulse in the cycle after a wrap tick
module pwm_multi #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pwm_en,
  input  logic [WIDTH-1:0]    period,
  input  logic [7:0]          prescale,
  input  logic                cfg_wr,
  input  logic [CW-1:0]       cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [WIDTH-1:0]    cfg_cmp1,
  input  logic [WIDTH-1:0]    cfg_cmp2,
  input  logic                cfg_pol,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [WIDTH-1:0]    count_val,
  output logic                period_done
);

  typedef enum logic [1:0] {
    ModeLeft   = 2'd0,
    ModeRight  = 2'd1,
    ModeCenter = 2'd2,
    ModeWindow = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e            mode;
    logic [WIDTH-1:0] cmp1;
    logic [WIDTH-1:0] cmp2;
    logic             pol;
  } ch_cfg_t;

  logic [7:0]          pre_q, pre_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    period_act_q, period_act_d;
  logic                period_done_q, period_done_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  ch_cfg_t             shadow_q [CHANNELS];
  ch_cfg_t             shadow_d [CHANNELS];
  ch_cfg_t             active_q [CHANNELS];
  ch_cfg_t             active_d [CHANNELS];

  logic tick;
  logic wrap;
  logic commit;

  assign tick   = pwm_en && (pre_q == prescale);
  // Also covers period_act = 0: the counter sits at 0 and every tick is a wrap.
  assign wrap   = tick && (count_q >= period_act_q);
  assign commit = wrap || !pwm_en;

  // Raw channel level for counter value c against the active terminal count p.
  function automatic logic raw_level(input ch_cfg_t cfg, input logic [WIDTH-1:0] c,
                                     input logic [WIDTH-1:0] p);
    logic lvl;
    lvl = 1'b0;
    unique case (cfg.mode)
      ModeLeft:   lvl = (c < cfg.cmp1);
      ModeRight:  lvl = (c >= cfg.cmp1);
      // Guard first so p - cmp1 is only evaluated when it cannot underflow.
      ModeCenter: lvl = (cfg.cmp1 <= (p >> 1)) && (c >= cfg.cmp1) && (c <= p - cfg.cmp1);
      ModeWindow: lvl = (c >= cfg.cmp1) && (c < cfg.cmp2);
      default:    lvl = 1'b0;
    endcase
    return lvl;
  endfunction

  // Prescaler, counter and period latch.
  always_comb begin
    pre_d         = pre_q;
    count_d       = count_q;
    period_act_d  = period_act_q;
    period_done_d = 1'b0;
    if (!pwm_en) begin
      pre_d        = '0;
      count_d      = '0;
      period_act_d = period;
    end else begin
      pre_d = tick ? 8'd0 : pre_q + 8'd1;
      if (wrap) begin
        count_d       = '0;
        period_act_d  = period;
        period_done_d = 1'b1;
      end else if (tick) begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  // Shadow writes, with write-through into the active set on a commit cycle.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (cfg_wr && (cfg_ch == CW'(i))) begin
        shadow_d[i] = '{mode: mode_e'(cfg_mode), cmp1: cfg_cmp1, cmp2: cfg_cmp2, pol: cfg_pol};
      end
      active_d[i] = commit ? shadow_d[i] : active_q[i];
    end
  end

  // Output levels are computed from the current count and registered, so pwm_out lags
  // count_val by one clock.
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (pwm_en) begin
        pwm_d[i] = raw_level(active_q[i], count_q, period_act_q) ^ active_q[i].pol;
      end else begin
        pwm_d[i] = active_q[i].pol;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q         <= '0;
      count_q       <= '0;
      period_act_q  <= '0;
      period_done_q <= 1'b0;
      pwm_q         <= '0;
    end else begin
      pre_q         <= pre_d;
      count_q       <= count_d;
      period_act_q  <= period_act_d;
      period_done_q <= period_done_d;
      pwm_q         <= pwm_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign pwm_out     = pwm_q;
  assign count_val   = count_q;
  assign period_done = period_done_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Testbench for pwm_multi: a behavioural model predicts every clock's outputs into a queue,
// a monitor pops and compares one cycle later. Directed duty/pulse counts and reset checks
// are layered on top of randomized configuration traffic.
module tb_pwm_multi;
  localparam int W  = 16;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pwm_en = 1'b0;
  logic [W-1:0]  period = '0;
  logic [7:0]    prescale = '0;
  logic          cfg_wr = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [1:0]    cfg_mode = '0;
  logic [W-1:0]  cfg_cmp1 = '0;
  logic [W-1:0]  cfg_cmp2 = '0;
  logic          cfg_pol = 1'b0;
  logic [CH-1:0] pwm_out;
  logic [W-1:0]  count_val;
  logic          period_done;

  pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_en      (pwm_en),
    .period      (period),
    .prescale    (prescale),
    .cfg_wr      (cfg_wr),
    .cfg_ch      (cfg_ch),
    .cfg_mode    (cfg_mode),
    .cfg_cmp1    (cfg_cmp1),
    .cfg_cmp2    (cfg_cmp2),
    .cfg_pol     (cfg_pol),
    .pwm_out     (pwm_out),
    .count_val   (count_val),
    .period_done (period_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int mode; int cmp1; int cmp2; bit pol; } mcfg_t;
  typedef struct { logic [CH-1:0] out; int cnt; bit done; } exp_t;

  mcfg_t m_sh  [CH];
  mcfg_t m_act [CH];
  int    m_pre, m_cnt, m_pact;
  bit    m_tick, m_wrap;
  exp_t  m_e;
  exp_t  expq [$];

  function automatic bit ref_level(mcfg_t c, int cnt, int p);
    case (c.mode)
      0:       return cnt < c.cmp1;
      1:       return cnt >= c.cmp1;
      2:       return (c.cmp1 <= p / 2) && (cnt >= c.cmp1) && (cnt <= p - c.cmp1);
      default: return (cnt >= c.cmp1) && (cnt < c.cmp2);
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        m_sh[i]  = '{0, 0, 0, 1'b0};
        m_act[i] = '{0, 0, 0, 1'b0};
      end
      m_pre = 0; m_cnt = 0; m_pact = 0;
      expq.delete();
    end else begin
      m_wrap = 1'b0;
      if (pwm_en) begin
        for (int i = 0; i < CH; i++) m_e.out[i] = ref_level(m_act[i], m_cnt, m_pact) ^ m_act[i].pol;
        m_tick = (m_pre == int'(prescale));
        m_wrap = m_tick && (m_cnt >= m_pact);
        m_pre  = m_tick ? 0 : (m_pre + 1) % 256;
        if (m_wrap) m_cnt = 0;
        else if (m_tick) m_cnt = m_cnt + 1;
      end else begin
        for (int i = 0; i < CH; i++) m_e.out[i] = m_act[i].pol;
        m_pre = 0;
        m_cnt = 0;
      end
      m_e.done = m_wrap;
      if (cfg_wr) m_sh[cfg_ch] = '{int'(cfg_mode), int'(cfg_cmp1), int'(cfg_cmp2), cfg_pol};
      if (!pwm_en || m_wrap) begin
        m_act  = m_sh;
        m_pact = int'(period);
      end
      m_e.cnt = m_cnt;
      expq.push_back(m_e);
    end
  end

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (expq.size() == 0) begin
        chk("scoreboard_underflow", 0, 1);
      end else begin
        mon_e = expq.pop_front();
        chk("pwm_out", int'(pwm_out), int'(mon_e.out));
        chk("count_val", int'(count_val), mon_e.cnt);
        chk("period_done", int'(period_done), int'(mon_e.done));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cfg_write(input int ch, input int mode, input int c1, input int c2, input bit pol);
    cfg_wr   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_mode = 2'(mode);
    cfg_cmp1 = W'(c1);
    cfg_cmp2 = W'(c2);
    cfg_pol  = pol;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  int h0, h1, h2, h3, dn, chg;
  logic [W-1:0] prev_cnt;

  task automatic measure(input int n);
    h0 = 0; h1 = 0; h2 = 0; h3 = 0; dn = 0; chg = 0;
    prev_cnt = count_val;
    repeat (n) begin
      @(negedge clk);
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      h2 += int'(pwm_out[2]);
      h3 += int'(pwm_out[3]);
      dn += int'(period_done);
      if (count_val != prev_cnt) chg++;
      prev_cnt = count_val;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_pwm_out", int'(pwm_out), 0);
    chk("reset_count", int'(count_val), 0);
    chk("reset_done", int'(period_done), 0);
    rst_n = 1'b1;

    // Idle configuration commits immediately.
    cfg_write(0, 0, 3, 0, 1'b0);
    cfg_write(1, 3, 2, 7, 1'b1);
    cfg_write(2, 2, 2, 0, 1'b0);
    cfg_write(3, 1, 0, 0, 1'b0);
    period = 9; prescale = 0;
    @(negedge clk);
    pwm_en = 1'b1;
    repeat (20) @(negedge clk);
    measure(20);
    chk("left_duty_3of10", h0, 6);
    chk("window_pol_high", h1, 10);
    chk("center_2to7", h2, 12);
    chk("right_cmp0_high", h3, 20);
    chk("done_every_10", dn, 2);

    // Running writes take effect after the next wrap.
    cfg_write(0, 0, 8, 0, 1'b0);
    cfg_write(1, 3, 7, 2, 1'b1);
    cfg_write(2, 2, 5, 0, 1'b0);
    repeat (15) @(negedge clk);
    measure(20);
    chk("left_duty_8of10", h0, 16);
    chk("window_empty_pol", h1, 20);
    chk("center_too_wide", h2, 0);

    // Slow prescaler.
    pwm_en = 1'b0;
    prescale = 2; period = 3;
    @(negedge clk);
    pwm_en = 1'b1;
    repeat (13) @(negedge clk);
    measure(24);
    chk("prescale_done_pulses", dn, 2);
    chk("prescale_count_steps", chg, 8);
    repeat (4) @(negedge clk);
    pwm_en = 1'b0;
    @(negedge clk);
    chk("idle_count", int'(count_val), 0);
    chk("idle_pol_level", int'(pwm_out), 2);

    // Randomized traffic.
    for (int k = 0; k < 2500; k++) begin
      if (!pwm_en) begin
        if ($urandom_range(0, 3) == 0) prescale = 8'($urandom_range(0, 3));
        pwm_en = ($urandom_range(0, 2) != 0);
      end else if ($urandom_range(0, 39) == 0) begin
        pwm_en = 1'b0;
      end
      if ($urandom_range(0, 29) == 0) period = W'($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0) begin
        cfg_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 13)), int'($urandom_range(0, 13)),
                  1'($urandom_range(0, 1)));
      end else begin
        @(negedge clk);
      end
    end

    // Reset mid-period with a pending shadow write.
    pwm_en = 1'b0; prescale = 0; period = 9;
    cfg_write(0, 0, 0, 0, 1'b0);
    @(negedge clk);
    pwm_en = 1'b1;
    for (int k = 0; k < 50 && count_val != 2; k++) @(negedge clk);
    chk("sync_count", int'(count_val), 2);
    cfg_write(0, 1, 5, 0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_pwm_out", int'(pwm_out), 0);
    chk("async_reset_count", int'(count_val), 0);
    @(negedge clk);
    rst_n = 1'b1;
    measure(30);
    chk("stale_write_gone", h0, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
